tzn_iter: RTL and testbench

Parametrised, multi-cycle trailing- or leading-zero counter with a normalising shifter, for the GCD datapath.
- Scans the operand one CHUNK-bit slice per cycle and stops early at the first non-zero slice.
- Returns the zero count, an all-zeros flag, and the operand shifted so the found one sits at bit 0 (trailing mode) or at bit WIDTH-1 (leading mode).
- Valid/ready on both sides, so the GCD controller can stall it.

---
 rtl/tzn_iter.sv | 114 +++++++++++
 tb/tb_tzn_iter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tzn_iter.sv
// tzn_iter: iterative trailing/leading zero counter with normalising shift.
// Scans CHUNK bits per cycle and stops early at the first non-zero slice.
module tzn_iter #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [WIDTH-1:0]         a_i,
   input  logic                     mode_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [$clog2(WIDTH):0]   numz_o,
   output logic                     all_zeros_o,
   output logic [WIDTH-1:0]         shifted_o
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int NW = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q;
   logic [WIDTH-1:0] op_q;
   logic             mode_q;
   logic [IW-1:0]    idx_q;
   logic [NW-1:0]    numz_q;
   logic             allz_q;
   logic [WIDTH-1:0] shifted_q;

   logic [WIDTH-1:0] scan_w;
   logic [WIDTH-1:0] scan_sh;
   logic [CHUNK-1:0] slice;
   logic [NW-1:0]    base;
   logic [NW-1:0]    numz_c;
   logic [WIDTH-1:0] sh_c;
   logic             hit;
   logic             last;

   function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
      return r;
   endfunction

   function automatic logic [NW-1:0] tz(input logic [CHUNK-1:0] s);
      logic [NW-1:0] r;
      r = '0;
      for (int i = CHUNK-1; i >= 0; i--) if (s[i]) r = NW'(i);
      return r;
   endfunction

   // Leading zeros are the trailing zeros of the bit-reversed operand.
   always_comb begin
      scan_w  = mode_q ? rev(op_q) : op_q;
      base    = NW'(idx_q) * NW'(CHUNK);
      scan_sh = scan_w >> base;
      slice   = scan_sh[CHUNK-1:0];
      hit     = |slice;
      last    = (idx_q == IW'(NCHUNK-1));
      numz_c  = base + tz(slice);
      sh_c    = mode_q ? (op_q << numz_c) : (op_q >> numz_c);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         op_q      <= '0;
         mode_q    <= 1'b0;
         idx_q     <= '0;
         numz_q    <= '0;
         allz_q    <= 1'b0;
         shifted_q <= '0;
      end else begin
         unique case (1'b1)
            (state_q == IDLE): begin
               if (in_valid_i) begin
                  op_q    <= a_i;
                  mode_q  <= mode_i;
                  idx_q   <= '0;
                  state_q <= SCAN;
               end
            end
            (state_q == SCAN): begin
               if (hit || last) begin
                  numz_q    <= hit ? numz_c : NW'(WIDTH);
                  allz_q    <= !hit;
                  shifted_q <= hit ? sh_c : '0;
                  state_q   <= DONE;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            (state_q == DONE): begin
               if (out_ready_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready_o  = (state_q == IDLE) && !rst_i;
   assign out_valid_o = (state_q == DONE);
   assign numz_o      = numz_q;
   assign all_zeros_o = allz_q;
   assign shifted_o   = shifted_q;

endmodule

// File: tb/tb_tzn_iter.sv
// tb_tzn_iter: directed vectors with a result scoreboard for tzn_iter.
// Expectations are queued at issue; a monitor pops and compares on out_valid.
module tb_tzn_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic        mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [5:0]  numz;
   logic        allz;
   logic [31:0] shifted;

   typedef struct {
      logic [5:0]  numz;
      logic        allz;
      logic [31:0] sh;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   tzn_iter #(.WIDTH(32), .CHUNK(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .mode_i(mode),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .numz_o(numz), .all_zeros_o(allz), .shifted_o(shifted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) acc_cyc <= cyc;
   end

   // Monitor: compare once when valid rises, then check hold stability.
   logic        seen = 1'b0;
   logic [5:0]  h_numz;
   logic        h_allz;
   logic [31:0] h_sh;

   always @(negedge clk) begin
      if (out_valid && !seen) begin
         seen = 1'b1;
         h_numz = numz;
         h_allz = allz;
         h_sh = shifted;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: numz=%0d", numz);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("numz", 64'(numz), 64'(e.numz));
            chk("allz", 64'(allz), 64'(e.allz));
            chk("shifted", 64'(shifted), 64'(e.sh));
            chk("latency", 64'(cyc - acc_cyc - 1), 64'(e.lat));
         end
      end else if (out_valid && seen) begin
         chk("hold_numz", 64'(numz), 64'(h_numz));
         chk("hold_sh", 64'(shifted), 64'(h_sh));
         chk("hold_allz", 64'(allz), 64'(h_allz));
      end else if (!out_valid) begin
         seen = 1'b0;
      end
   end

   task automatic issue(input logic [31:0] av, input logic m,
                        input logic [5:0] nz, input logic az,
                        input logic [31:0] sh, input int lat,
                        input bit push);
      exp_t e;
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL in_ready_timeout: got 0 want 1");
      end
      e.numz = nz;
      e.allz = az;
      e.sh = sh;
      e.lat = lat;
      if (push) q.push_back(e);
      in_valid = 1'b1;
      a = av;
      mode = m;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         total++;
         bad++;
         $display("FAIL out_valid_timeout: got 0 want 1");
      end
      n = 0;
      while (out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run(input logic [31:0] av, input logic m,
                      input logic [5:0] nz, input logic az,
                      input logic [31:0] sh, input int lat);
      issue(av, m, nz, az, sh, lat, 1'b1);
      wait_done();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_numz", 64'(numz), 64'd0);
      chk("rst_shifted", 64'(shifted), 64'd0);
      rst = 1'b0;
      #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      run(32'h0000_0001, 1'b0, 6'd0,  1'b0, 32'h0000_0001, 1);
      run(32'h8000_0000, 1'b0, 6'd31, 1'b0, 32'h0000_0001, 4);
      run(32'h0000_0C00, 1'b0, 6'd10, 1'b0, 32'h0000_0003, 2);
      run(32'h00F0_0000, 1'b0, 6'd20, 1'b0, 32'h0000_000F, 3);
      run(32'h0000_0000, 1'b0, 6'd32, 1'b1, 32'h0000_0000, 4);
      run(32'h0000_0000, 1'b1, 6'd32, 1'b1, 32'h0000_0000, 4);
      run(32'h0001_0000, 1'b1, 6'd15, 1'b0, 32'h8000_0000, 2);
      run(32'hFFFF_FFFF, 1'b1, 6'd0,  1'b0, 32'hFFFF_FFFF, 1);
      run(32'h0000_0001, 1'b1, 6'd31, 1'b0, 32'h8000_0000, 4);

      // Backpressure: stall in DONE while offering new operands.
      out_ready = 1'b0;
      issue(32'h0000_0C00, 1'b0, 6'd10, 1'b0, 32'h0000_0003, 2, 1'b1);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         a = 32'h1234_5670 + 32'(i);
         mode = 1'b1;
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 64'(out_valid), 64'd0);
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      run(32'h8000_0000, 1'b0, 6'd31, 1'b0, 32'h0000_0001, 4);

      // Reset mid-SCAN abandons the operation.
      issue(32'h0000_0000, 1'b0, 6'd0, 1'b0, 32'h0, 0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_numz", 64'(numz), 64'd0);
      chk("mid_rst_shifted", 64'(shifted), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("no_result_after_rst", 64'(out_valid), 64'd0);
      run(32'h0000_0100, 1'b0, 6'd8, 1'b0, 32'h0000_0001, 2);

      repeat (2) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
